// File: rtl/subtrator_serial_ctrl_if.sv
// Request/result bundle for the bit-serial subtractor controller.
// The V overflow flag exists only when SUBTRATOR_OVERFLOW_EN is defined.
interface subtrator_serial_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             BorrowIn;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] D;
    logic             BorrowOut;
`ifdef SUBTRATOR_OVERFLOW_EN
    logic             V;
`endif

    modport master (
        output start, A, B, BorrowIn,
        input  busy, done, D, BorrowOut
`ifdef SUBTRATOR_OVERFLOW_EN
        , input V
`endif
    );

    modport slave (
        input  start, A, B, BorrowIn,
        output busy, done, D, BorrowOut
`ifdef SUBTRATOR_OVERFLOW_EN
        , output V
`endif
    );
endinterface

// File: rtl/subtrator_serial_ctrl.sv
// Bit-serial D = A - B - BorrowIn using one full-subtractor cell, LSB first.
// Define SUBTRATOR_OVERFLOW_EN to add the two's-complement overflow output V.
module subtrator_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    subtrator_serial_ctrl_if.slave  bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_aShift;
    logic [WIDTH-1:0] r_bShift;
    logic [WIDTH-1:0] r_result;
    logic             r_borrow;
    logic [CW-1:0]    r_count;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_d;
    logic             r_borrowOut;

    logic             w_a;
    logic             w_b;
    logic             w_d;
    logic             w_bout;
    logic [WIDTH-1:0] w_resultNext;

    assign w_a          = r_aShift[0];
    assign w_b          = r_bShift[0];
    assign w_d          = w_a ^ w_b ^ r_borrow;
    assign w_bout       = (~w_a & w_b) | (~(w_a ^ w_b) & r_borrow);
    // Each difference bit enters at the MSB so the LSB lands at bit 0 after WIDTH shifts.
    assign w_resultNext = {w_d, r_result[WIDTH-1:1]};

`ifdef SUBTRATOR_OVERFLOW_EN
    logic r_aMsb;
    logic r_bMsb;
    logic r_v;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_aMsb <= 1'b0;
            r_bMsb <= 1'b0;
            r_v    <= 1'b0;
        end else if (r_state == IDLE && bus.start) begin
            r_aMsb <= bus.A[WIDTH-1];
            r_bMsb <= bus.B[WIDTH-1];
        end else if (r_state == RUN && r_count == LAST) begin
            r_v <= (r_aMsb != r_bMsb) && (w_d != r_aMsb);
        end
    end

    assign bus.V = r_v;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_aShift    <= '0;
            r_bShift    <= '0;
            r_result    <= '0;
            r_borrow    <= 1'b0;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_d         <= '0;
            r_borrowOut <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.start) begin
                        r_aShift <= bus.A;
                        r_bShift <= bus.B;
                        r_borrow <= bus.BorrowIn;
                        r_count  <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                    end
                end
                RUN: begin
                    r_aShift <= {1'b0, r_aShift[WIDTH-1:1]};
                    r_bShift <= {1'b0, r_bShift[WIDTH-1:1]};
                    r_result <= w_resultNext;
                    r_borrow <= w_bout;
                    r_count  <= r_count + CW'(1);
                    if (r_count == LAST) begin
                        r_d         <= w_resultNext;
                        r_borrowOut <= w_bout;
                        r_done      <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.D         = r_d;
    assign bus.BorrowOut = r_borrowOut;
endmodule

// File: tb/tb_subtrator_serial_ctrl.sv
// Scoreboard bench for subtrator_serial_ctrl; checks V when SUBTRATOR_OVERFLOW_EN is defined.
module tb_subtrator_serial_ctrl;
    localparam int WIDTH = 8;

    typedef struct {
        logic [WIDTH-1:0] d;
        logic             bout;
        logic             v;
    } exp_t;

    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    int   doneCount;
    logic prevDone;
    exp_t expQ[$];

    subtrator_serial_ctrl_if #(.WIDTH(WIDTH)) bus ();

    subtrator_serial_ctrl #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic exp_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic bin);
        exp_t             e;
        logic [WIDTH:0]   full;
        full   = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
        e.d    = full[WIDTH-1:0];
        e.bout = full[WIDTH];
        e.v    = (a[WIDTH-1] != b[WIDTH-1]) && (e.d[WIDTH-1] != a[WIDTH-1]);
        return e;
    endfunction

    // Drives one start pulse; returns at the negedge just after the accepting edge.
    task automatic applyStimulus(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                 input logic bin, input bit expectResult);
        @(negedge clk);
        bus.A        = a;
        bus.B        = b;
        bus.BorrowIn = bin;
        bus.start    = 1'b1;
        if (expectResult) expQ.push_back(model(a, b, bin));
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic waitDone(input string tag);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, {31'b0, bus.done}, 32'd1);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (bus.done === 1'b1) begin
            exp_t e;
            doneCount++;
            checkOutput("doneSingleCycle", {31'b0, prevDone}, 32'd0);
            if (expQ.size() == 0) begin
                checkOutput("unexpectedDone", 32'd1, 32'd0);
            end else begin
                e = expQ.pop_front();
                checkOutput("D", {{(32-WIDTH){1'b0}}, bus.D}, {{(32-WIDTH){1'b0}}, e.d});
                checkOutput("BorrowOut", {31'b0, bus.BorrowOut}, {31'b0, e.bout});
`ifdef SUBTRATOR_OVERFLOW_EN
                checkOutput("V", {31'b0, bus.V}, {31'b0, e.v});
`endif
            end
        end
        prevDone = bus.done;
    end

    initial begin
        int busyLen;
        int doneAt;
        int doneBefore;
        errors       = 0;
        checks       = 0;
        doneCount    = 0;
        prevDone     = 1'b0;
        rst_n        = 1'b0;
        bus.start    = 1'b0;
        bus.A        = '0;
        bus.B        = '0;
        bus.BorrowIn = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rstBusy", {31'b0, bus.busy}, 32'd0);
        checkOutput("rstDone", {31'b0, bus.done}, 32'd0);
        checkOutput("rstD", {24'b0, bus.D}, 32'd0);
        checkOutput("rstBorrowOut", {31'b0, bus.BorrowOut}, 32'd0);
`ifdef SUBTRATOR_OVERFLOW_EN
        checkOutput("rstV", {31'b0, bus.V}, 32'd0);
`endif
        rst_n = 1'b1;

        // Latency and busy length on the first operation.
        applyStimulus(8'h05, 8'h03, 1'b0, 1'b1);
        busyLen = 0;
        doneAt  = 0;
        while (bus.busy === 1'b1 && busyLen < 50) begin
            busyLen++;
            if (bus.done === 1'b1) doneAt = busyLen;
            @(negedge clk);
        end
        checkOutput("busyLength", busyLen, WIDTH + 1);
        checkOutput("doneLatency", doneAt, WIDTH + 1);

        applyStimulus(8'h03, 8'h05, 1'b0, 1'b1);
        waitDone("doneOp2");
        applyStimulus(8'h00, 8'h00, 1'b1, 1'b1);
        waitDone("doneOp3");
        applyStimulus(8'hFF, 8'hFF, 1'b1, 1'b1);
        waitDone("doneOp4");

        // Starts while busy must be ignored and D must hold its prior value.
        doneBefore = doneCount;
        applyStimulus(8'h10, 8'h01, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        bus.A     = 8'h00;
        bus.B     = 8'hFF;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        checkOutput("holdDRun", {24'b0, bus.D}, 32'h0000_00FF);
        checkOutput("holdBorrowRun", {31'b0, bus.BorrowOut}, 32'd1);
        for (int i = 0; i < 50 && bus.done !== 1'b1; i++) @(negedge clk);
        checkOutput("doneOp5", {31'b0, bus.done}, 32'd1);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) begin
            checkOutput("ignoredStartBusy", {31'b0, bus.busy}, 32'd0);
            @(negedge clk);
        end
        checkOutput("singleDoneOp5", doneCount - doneBefore, 32'd1);

        // Reset in the middle of RUN abandons the operation.
        applyStimulus(8'h20, 8'h11, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checkOutput("midRstBusy", {31'b0, bus.busy}, 32'd0);
        checkOutput("midRstDone", {31'b0, bus.done}, 32'd0);
        checkOutput("midRstD", {24'b0, bus.D}, 32'd0);
        checkOutput("midRstBorrowOut", {31'b0, bus.BorrowOut}, 32'd0);
        doneBefore = doneCount;
        repeat (15) @(negedge clk);
        checkOutput("noDoneAfterRst", doneCount - doneBefore, 32'd0);
        applyStimulus(8'h09, 8'h04, 1'b0, 1'b1);
        waitDone("doneAfterRst");

`ifdef SUBTRATOR_OVERFLOW_EN
        applyStimulus(8'h80, 8'h01, 1'b0, 1'b1);
        waitDone("doneOvf1");
        applyStimulus(8'h7F, 8'hFF, 1'b0, 1'b1);
        waitDone("doneOvf2");
        applyStimulus(8'h05, 8'h03, 1'b0, 1'b1);
        waitDone("doneOvf3");
`endif

        for (int i = 0; i < 6; i++) begin
            applyStimulus(WIDTH'($urandom), WIDTH'($urandom), 1'($urandom_range(0, 1)), 1'b1);
            waitDone("doneRandom");
        end

        repeat (2) @(negedge clk);
        checkOutput("queueDrained", expQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/subtrator_serial_ctrl.md
Name: subtrator_serial_ctrl

Overview:
- Bit-serial N-bit subtractor controller: computes D = A - B - BorrowIn using a single 1-bit full-subtractor cell, one bit per clock, LSB first.
- Sequences operand shifting, borrow feedback and the start/busy/done handshake.
- Sits between a requesting block and the area-minimal subtraction datapath; trades WIDTH cycles of latency for a single cell.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend; captured on start acceptance.
- B  input  WIDTH  subtrahend; captured on start acceptance.
- BorrowIn  input  1  initial borrow; captured on start acceptance.
- busy  output  1  high in RUN and DONE.
- done  output  1  one-cycle pulse; result valid.
- D  output  WIDTH  difference (A - B - BorrowIn) mod 2^WIDTH.
- BorrowOut  output  1  final borrow; 1 when A < B + BorrowIn (unsigned).

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-low, on rst_n.
- Reset (rst_n = 0 at a clk edge): state = IDLE; busy = 0; done = 0; D = 0; BorrowOut = 0; counter, shift registers and borrow flop cleared.
  - Reset overrides all other inputs, including mid-RUN: the operation is abandoned and done is never issued for it.
- States: IDLE, RUN, DONE.
- IDLE:
  - On an edge with start = 1: capture A and B into shift registers and BorrowIn into the borrow flop; counter = 0; go to RUN; busy = 1 from this edge.
  - With start = 0: remain in IDLE.
- RUN (one bit per edge):
  - Cell inputs: a = A_sh[0], b = B_sh[0], bin = borrow flop.
  - Cell equations: d = a^b^bin; bout = (~a&b) | (~(a^b)&bin).
  - d shifts into the result register from the MSB side; A_sh and B_sh shift right; borrow flop = bout; counter increments.
  - On the edge where counter reaches WIDTH-1 (the WIDTH-th RUN edge): D = complete result register; BorrowOut = that edge's bout; done = 1; go to DONE.
- DONE: lasts one cycle; the next edge gives done = 0, busy = 0, state = IDLE.
- Latency: start accepted at edge 0; done high in the cycle following edge WIDTH; the next start can be accepted at edge WIDTH+2.
- start is ignored (not queued) while busy = 1, including in DONE; A, B and BorrowIn are don't-care outside the accepting edge.
- D and BorrowOut hold the previous result throughout RUN and update only at the DONE transition; both hold until the next completion or reset.
- Counter width: clog2(WIDTH); no wrap is possible because RUN exits at WIDTH-1.

Optional Feature:
- Macro: SUBTRATOR_OVERFLOW_EN.
- Defined:
  - Extra output port V (1 bit): two's-complement overflow, V = (A[WIDTH-1] != B[WIDTH-1]) && (D[WIDTH-1] != A[WIDTH-1]), computed from the captured operands and the final D.
  - V updates on the same edge as D; reset value 0; holds like D.
- Undefined: port V and its logic are absent; all other behaviour is identical.

Test Plan:
- WIDTH=8, reset then start with A=0x05, B=0x03, BorrowIn=0 -> done pulses one cycle after the 8th RUN edge; D=0x02, BorrowOut=0; busy high for exactly 9 cycles.
- A=0x03, B=0x05, BorrowIn=0 -> D=0xFE, BorrowOut=1.
- A=0x00, B=0x00, BorrowIn=1 -> D=0xFF, BorrowOut=1. A=0xFF, B=0xFF, BorrowIn=1 -> D=0xFF, BorrowOut=1.
- Start with A=0x10, B=0x01; pulse start with A=0x00, B=0xFF at RUN edge 3 and in DONE -> single done only; D=0x0F, BorrowOut=0; D held at its prior value during RUN.
- rst_n=0 for one edge at RUN edge 4 -> busy=0, done=0, D=0, BorrowOut=0 immediately; no done follows; next start with A=0x09, B=0x04 gives D=0x05.
- With SUBTRATOR_OVERFLOW_EN: A=0x80, B=0x01 -> D=0x7F, V=1, BorrowOut=0; A=0x7F, B=0xFF -> D=0x80, V=1, BorrowOut=1; A=0x05, B=0x03 -> V=0.
